// File: rtl/pc_return_stack.sv
// pc_return_stack: return-address stack paired with the program counter.
// A call pushes a return address; a return pops it. The popped address is
// presented one cycle later on ret_addr/ret_valid, which feed the counter's
// datain/load. Sticky overflow/underflow flags are cleared by clear_err.
// Build option: define RAS_CIRCULAR_EN to make a push while full overwrite
// the oldest entry; otherwise a push while full is dropped.
module pc_return_stack #(
   parameter int DATA_WIDTH = 16,
   parameter int DEPTH      = 8,
   localparam int CNT_W     = $clog2(DEPTH + 1)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  push,
   input  logic                  pop,
   input  logic [DATA_WIDTH-1:0] datain,
   input  logic                  clear_err,
   output logic [DATA_WIDTH-1:0] top,
   output logic [DATA_WIDTH-1:0] ret_addr,
   output logic                  ret_valid,
   output logic [CNT_W-1:0]      count,
   output logic                  empty,
   output logic                  full,
   output logic                  overflow,
   output logic                  underflow
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0]      wp;
   logic [PTR_W-1:0]      wp_m1;

   // next-state controls
   logic                  mem_we;
   logic [PTR_W-1:0]      mem_wa;
   logic                  wp_inc, wp_dec;
   logic                  cnt_inc, cnt_dec;
   logic                  ret_ld;
   logic                  ovf_set, unf_set;

   assign wp_m1 = wp - 1'b1;
   assign empty = (count == '0);
   assign full  = (count == CNT_W'(DEPTH));
   assign top   = empty ? '0 : mem[wp_m1];

   // decode push/pop against the current occupancy
   always_comb begin
      mem_we  = 1'b0;
      mem_wa  = wp;
      wp_inc  = 1'b0;
      wp_dec  = 1'b0;
      cnt_inc = 1'b0;
      cnt_dec = 1'b0;
      ret_ld  = 1'b0;
      ovf_set = 1'b0;
      unf_set = 1'b0;
      if (push && pop) begin
         if (!empty) begin
            // return immediately followed by a call: swap the top entry
            mem_we = 1'b1;
            mem_wa = wp_m1;
            ret_ld = 1'b1;
         end else begin
            // nothing to return; the push still lands
            unf_set = 1'b1;
            mem_we  = 1'b1;
            wp_inc  = 1'b1;
            cnt_inc = 1'b1;
         end
      end else if (push) begin
         if (!full) begin
            mem_we  = 1'b1;
            wp_inc  = 1'b1;
            cnt_inc = 1'b1;
         end else begin
            ovf_set = 1'b1;
`ifdef RAS_CIRCULAR_EN
            // overwrite the oldest slot; count saturates at DEPTH
            mem_we = 1'b1;
            wp_inc = 1'b1;
`endif
         end
      end else if (pop) begin
         if (!empty) begin
            ret_ld  = 1'b1;
            wp_dec  = 1'b1;
            cnt_dec = 1'b1;
         end else begin
            unf_set = 1'b1;
         end
      end
   end

   // address storage; contents are don't-care out of reset
   always_ff @(posedge clk) begin
      if (mem_we) mem[mem_wa] <= datain;
   end

   // pointer, occupancy, return strobe and sticky error flags
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wp        <= '0;
         count     <= '0;
         ret_addr  <= '0;
         ret_valid <= 1'b0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (wp_inc)       wp <= wp + 1'b1;
         else if (wp_dec)  wp <= wp_m1;
         if (cnt_inc)      count <= count + 1'b1;
         else if (cnt_dec) count <= count - 1'b1;
         ret_valid <= ret_ld;
         if (ret_ld) ret_addr <= top;
         // a new error in the clearing cycle wins
         overflow  <= (overflow  & ~clear_err) | ovf_set;
         underflow <= (underflow & ~clear_err) | unf_set;
      end
   end

endmodule
